// File: rtl/regfile_wb_ctrl_if.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | regfile_wb_ctrl_if : writeback source handshakes (A pipeline, B long-lat) |
// | Revision 1.0                                                              |
// +---------------------------------------------------------------------------+
interface regfile_wb_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              a_valid;
  logic              a_ready;
  logic [ADDR_W-1:0] a_rd;
  logic [DATA_W-1:0] a_data;
  logic              b_valid;
  logic              b_ready;
  logic [ADDR_W-1:0] b_rd;
  logic [DATA_W-1:0] b_data;

  modport master (
    output a_valid, a_rd, a_data, b_valid, b_rd, b_data,
    input  a_ready, b_ready
  );

  modport slave (
    input  a_valid, a_rd, a_data, b_valid, b_rd, b_data,
    output a_ready, b_ready
  );
endinterface
`default_nettype wire

// File: rtl/regfile_wb_ctrl.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | regfile_wb_ctrl : register-file write-port arbiter and pending scoreboard |
// | Revision 1.0                                                              |
// +---------------------------------------------------------------------------+
module regfile_wb_ctrl #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  regfile_wb_ctrl_if.slave  wb,
  input  logic              iss_valid,
  input  logic [ADDR_W-1:0] iss_rd,
  input  logic [ADDR_W-1:0] chk_ra,
  input  logic [ADDR_W-1:0] chk_rb,
  output logic              stall,
  output logic              iss_conflict,
  output logic              RegWr,
  output logic [ADDR_W-1:0] RW,
  output logic [DATA_W-1:0] BusW
);

  localparam int NREG  = 1 << ADDR_W;
  localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0]  starve_q, starve_d;
  logic [NREG-1:0]   pending_q, pending_d;
  logic              conflict_q, conflict_d;
  logic              regwr_q, regwr_d;
  logic [ADDR_W-1:0] rw_q, rw_d;
  logic [DATA_W-1:0] busw_q, busw_d;

  logic b_prio;
  logic grant_a;
  logic grant_b;
  logic iss_set;

  // Grants are masked by rst_n so nothing is accepted while reset is held.
  always_comb begin
    b_prio  = (starve_q >= STARVE_LIM);
    grant_b = rst_n && wb.b_valid && (!wb.a_valid || b_prio);
    grant_a = rst_n && wb.a_valid && !grant_b;
    iss_set = iss_valid && (iss_rd != '0);
  end

  assign wb.a_ready = grant_a;
  assign wb.b_ready = grant_b;

  assign stall = ((chk_ra != '0) && pending_q[chk_ra]) ||
                 ((chk_rb != '0) && pending_q[chk_rb]) ||
                 (iss_set && ((iss_rd == chk_ra) || (iss_rd == chk_rb)));

  always_comb begin
    starve_d   = starve_q;
    pending_d  = pending_q;
    conflict_d = conflict_q | (iss_set && pending_q[iss_rd]);
    regwr_d    = 1'b0;
    rw_d       = rw_q;
    busw_d     = busw_q;

    if (!wb.b_valid || grant_b) begin
      starve_d = '0;
    end else if (starve_q < STARVE_LIM) begin
      starve_d = starve_q + CNT_W'(1);
    end

    // Clear before set so a same-cycle reissue keeps the register pending.
    if (grant_b && (wb.b_rd != '0)) begin
      pending_d[wb.b_rd] = 1'b0;
    end
    if (iss_set) begin
      pending_d[iss_rd] = 1'b1;
    end

    if (grant_a) begin
      rw_d    = wb.a_rd;
      busw_d  = wb.a_data;
      regwr_d = (wb.a_rd != '0);
    end else if (grant_b) begin
      rw_d    = wb.b_rd;
      busw_d  = wb.b_data;
      regwr_d = (wb.b_rd != '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q   <= '0;
      pending_q  <= '0;
      conflict_q <= 1'b0;
      regwr_q    <= 1'b0;
      rw_q       <= '0;
      busw_q     <= '0;
    end else begin
      starve_q   <= starve_d;
      pending_q  <= pending_d;
      conflict_q <= conflict_d;
      regwr_q    <= regwr_d;
      rw_q       <= rw_d;
      busw_q     <= busw_d;
    end
  end

  assign iss_conflict = conflict_q;
  assign RegWr        = regwr_q;
  assign RW           = rw_q;
  assign BusW         = busw_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_ctrl.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_regfile_wb_ctrl : directed and randomized bench for regfile_wb_ctrl    |
// | Revision 1.0                                                              |
// +---------------------------------------------------------------------------+
module tb_regfile_wb_ctrl;
  localparam int DATA_W     = 32;
  localparam int ADDR_W     = 5;
  localparam int STARVE_MAX = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  regfile_wb_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) wb ();

  logic              iss_valid;
  logic [ADDR_W-1:0] iss_rd, chk_ra, chk_rb;
  logic              stall, iss_conflict, RegWr;
  logic [ADDR_W-1:0] RW;
  logic [DATA_W-1:0] BusW;

  regfile_wb_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .STARVE_MAX(STARVE_MAX)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wb           (wb.slave),
    .iss_valid    (iss_valid),
    .iss_rd       (iss_rd),
    .chk_ra       (chk_ra),
    .chk_rb       (chk_rb),
    .stall        (stall),
    .iss_conflict (iss_conflict),
    .RegWr        (RegWr),
    .RW           (RW),
    .BusW         (BusW)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: set of outstanding registers, count of B's consecutive
  // denials, and the last write presented to the register file.
  bit                m_pend [32];
  int                m_wait;
  bit                m_conf;
  bit                m_regwr;
  logic [ADDR_W-1:0] m_rw;
  logic [DATA_W-1:0] m_busw;

  function automatic void model_reset();
    foreach (m_pend[i]) m_pend[i] = 1'b0;
    m_wait  = 0;
    m_conf  = 1'b0;
    m_regwr = 1'b0;
    m_rw    = '0;
    m_busw  = '0;
  endfunction

  function automatic void model_grant(output bit ga, output bit gb);
    ga = 1'b0;
    gb = 1'b0;
    if (rst_n) begin
      if (wb.a_valid && wb.b_valid) begin
        if (m_wait >= STARVE_MAX) gb = 1'b1;
        else                      ga = 1'b1;
      end else if (wb.a_valid) begin
        ga = 1'b1;
      end else if (wb.b_valid) begin
        gb = 1'b1;
      end
    end
  endfunction

  function automatic bit model_stall();
    bit hit_ra = (chk_ra != 0) && m_pend[chk_ra];
    bit hit_rb = (chk_rb != 0) && m_pend[chk_rb];
    bit hit_is = iss_valid && (iss_rd != 0) && (iss_rd == chk_ra || iss_rd == chk_rb);
    return hit_ra || hit_rb || hit_is;
  endfunction

  // Advance one clock and bring the model along with it.
  task automatic tick();
    bit ga, gb;
    model_grant(ga, gb);
    @(posedge clk);
    if (ga || gb) begin
      m_rw    = ga ? wb.a_rd : wb.b_rd;
      m_busw  = ga ? wb.a_data : wb.b_data;
      m_regwr = (m_rw != 0);
    end else begin
      m_regwr = 1'b0;
    end
    if (!wb.b_valid || gb) m_wait = 0;
    else if (m_wait < STARVE_MAX) m_wait = m_wait + 1;
    if (iss_valid && iss_rd != 0 && m_pend[iss_rd]) m_conf = 1'b1;
    if (gb && wb.b_rd != 0) m_pend[wb.b_rd] = 1'b0;
    if (iss_valid && iss_rd != 0) m_pend[iss_rd] = 1'b1;
    #1;
  endtask

  task automatic idle();
    wb.a_valid = 1'b0; wb.a_rd = '0; wb.a_data = '0;
    wb.b_valid = 1'b0; wb.b_rd = '0; wb.b_data = '0;
    iss_valid = 1'b0; iss_rd = '0; chk_ra = '0; chk_rb = '0;
  endtask

  task automatic test_reset();
    idle();
    model_reset();
    wb.a_valid = 1'b1; wb.a_rd = 5'd5; wb.a_data = 32'h5555_AAAA;
    #12;
    checks++; if (RegWr !== 1'b0) begin errors++; $display("FAIL reset_regwr: got %b expected 0", RegWr); end
    checks++; if (RW !== '0) begin errors++; $display("FAIL reset_rw: got %0d expected 0", RW); end
    checks++; if (BusW !== '0) begin errors++; $display("FAIL reset_busw: got %h expected 0", BusW); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", stall); end
    checks++; if (wb.a_ready !== 1'b0) begin errors++; $display("FAIL reset_a_ready: got %b expected 0", wb.a_ready); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    checks++; if (wb.a_ready !== 1'b1) begin errors++; $display("FAIL release_a_ready: got %b expected 1", wb.a_ready); end
    tick();
    checks++; if (RegWr !== 1'b1 || RW !== 5'd5) begin errors++; $display("FAIL release_write: got RegWr=%b RW=%0d expected 1/5", RegWr, RW); end
    idle();
    tick();
  endtask

  task automatic test_a_only();
    wb.a_valid = 1'b1; wb.a_rd = 5'd7; wb.a_data = 32'hDEAD_BEEF;
    #1;
    checks++; if (wb.a_ready !== 1'b1 || wb.b_ready !== 1'b0) begin errors++; $display("FAIL a_only_ready: got a=%b b=%b expected 1/0", wb.a_ready, wb.b_ready); end
    tick();
    idle();
    checks++; if (RegWr !== 1'b1) begin errors++; $display("FAIL a_only_regwr: got %b expected 1", RegWr); end
    checks++; if (RW !== 5'd7) begin errors++; $display("FAIL a_only_rw: got %0d expected 7", RW); end
    checks++; if (BusW !== 32'hDEAD_BEEF) begin errors++; $display("FAIL a_only_busw: got %h expected deadbeef", BusW); end
    tick();
    checks++; if (RegWr !== 1'b0 || RW !== 5'd7) begin errors++; $display("FAIL a_only_after: got RegWr=%b RW=%0d expected 0/7", RegWr, RW); end
  endtask

  task automatic test_r0_drop();
    wb.b_valid = 1'b1; wb.b_rd = 5'd0; wb.b_data = 32'h0000_1234;
    #1;
    checks++; if (wb.b_ready !== 1'b1) begin errors++; $display("FAIL r0_b_ready: got %b expected 1", wb.b_ready); end
    tick();
    idle();
    checks++; if (RegWr !== 1'b0) begin errors++; $display("FAIL r0_regwr: got %b expected 0", RegWr); end
    checks++; if (BusW !== 32'h0000_1234 || RW !== 5'd0) begin errors++; $display("FAIL r0_bus: got RW=%0d BusW=%h expected 0/1234", RW, BusW); end
    tick();
  endtask

  task automatic test_starvation();
    wb.a_valid = 1'b1; wb.a_rd = 5'd10; wb.a_data = 32'hAAAA_0010;
    wb.b_valid = 1'b1; wb.b_rd = 5'd11; wb.b_data = 32'hBBBB_0011;
    for (int i = 0; i < 6; i++) begin
      bit exp_a = (i != STARVE_MAX);
      #1;
      checks++;
      if (wb.a_ready !== exp_a || wb.b_ready !== !exp_a) begin
        errors++;
        $display("FAIL starve_grant[%0d]: got a=%b b=%b expected a=%b b=%b", i, wb.a_ready, wb.b_ready, exp_a, !exp_a);
      end
      tick();
      checks++;
      if (RW !== (exp_a ? 5'd10 : 5'd11)) begin
        errors++;
        $display("FAIL starve_rw[%0d]: got %0d expected %0d", i, RW, exp_a ? 10 : 11);
      end
    end
    idle();
    tick();
  endtask

  task automatic test_scoreboard();
    iss_valid = 1'b1; iss_rd = 5'd9; chk_ra = 5'd9;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL sb_issue_fwd: got %b expected 1", stall); end
    tick();
    iss_valid = 1'b0; iss_rd = '0;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL sb_pending: got %b expected 1", stall); end
    chk_ra = '0; chk_rb = '0; iss_valid = 1'b1; iss_rd = '0;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL sb_r0_nostall: got %b expected 0", stall); end
    tick();
    iss_valid = 1'b0;
    chk_rb = 5'd9;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL sb_chk_rb: got %b expected 1", stall); end
    chk_rb = '0; chk_ra = 5'd9;
    wb.b_valid = 1'b1; wb.b_rd = 5'd9; wb.b_data = 32'h9999_0009;
    #1;
    checks++; if (wb.b_ready !== 1'b1 || stall !== 1'b1) begin errors++; $display("FAIL sb_accept: got b_ready=%b stall=%b expected 1/1", wb.b_ready, stall); end
    tick();
    wb.b_valid = 1'b0;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL sb_cleared: got %b expected 0", stall); end
    checks++; if (RegWr !== 1'b1 || BusW !== 32'h9999_0009) begin errors++; $display("FAIL sb_b_write: got RegWr=%b BusW=%h expected 1/99990009", RegWr, BusW); end
    idle();
    tick();
  endtask

  task automatic test_conflict();
    iss_valid = 1'b1; iss_rd = 5'd4;
    tick();
    checks++; if (iss_conflict !== 1'b0) begin errors++; $display("FAIL conf_first: got %b expected 0", iss_conflict); end
    tick();
    checks++; if (iss_conflict !== 1'b1) begin errors++; $display("FAIL conf_second: got %b expected 1", iss_conflict); end
    iss_valid = 1'b0;
    tick();
    checks++; if (iss_conflict !== 1'b1) begin errors++; $display("FAIL conf_sticky: got %b expected 1", iss_conflict); end
    wb.b_valid = 1'b1; wb.b_rd = 5'd4; wb.b_data = 32'h4444_0004;
    tick();
    wb.b_valid = 1'b0; chk_ra = 5'd4;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL conf_b_clear: got %b expected 0", stall); end
    chk_ra = '0;
    wb.b_valid = 1'b1; iss_valid = 1'b1; iss_rd = 5'd4;
    tick();
    idle();
    chk_ra = 5'd4;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL conf_set_wins: got %b expected 1", stall); end
  endtask

  task automatic test_reset_midop();
    wb.a_valid = 1'b1; wb.a_rd = 5'd3; wb.a_data = 32'h3333_0003;
    tick();
    checks++; if (RegWr !== 1'b1) begin errors++; $display("FAIL midop_write: got %b expected 1", RegWr); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (RegWr !== 1'b0 || RW !== '0 || BusW !== '0) begin errors++; $display("FAIL midop_out: got RegWr=%b RW=%0d BusW=%h expected 0/0/0", RegWr, RW, BusW); end
    checks++; if (stall !== 1'b0 || iss_conflict !== 1'b0) begin errors++; $display("FAIL midop_sb: got stall=%b conflict=%b expected 0/0", stall, iss_conflict); end
    checks++; if (wb.a_ready !== 1'b0) begin errors++; $display("FAIL midop_a_ready: got %b expected 0", wb.a_ready); end
    model_reset();
    idle();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    bit a_hold = 1'b0;
    bit b_hold = 1'b0;
    for (int n = 0; n < 400; n++) begin
      bit ga, gb, exp_stall;
      if (!a_hold) begin
        wb.a_valid = 1'($urandom_range(0, 1));
        wb.a_rd    = 5'($urandom_range(0, 7));
        wb.a_data  = $urandom;
      end
      if (!b_hold) begin
        wb.b_valid = 1'($urandom_range(0, 1));
        wb.b_rd    = 5'($urandom_range(0, 7));
        wb.b_data  = $urandom;
      end
      iss_valid = ($urandom_range(0, 3) == 0);
      iss_rd    = 5'($urandom_range(0, 7));
      chk_ra    = 5'($urandom_range(0, 7));
      chk_rb    = 5'($urandom_range(0, 7));
      #1;
      model_grant(ga, gb);
      exp_stall = model_stall();
      checks++;
      if (wb.a_ready !== ga || wb.b_ready !== gb || stall !== exp_stall) begin
        errors++;
        $display("FAIL rand_comb[%0d]: got a=%b b=%b stall=%b expected a=%b b=%b stall=%b",
                 n, wb.a_ready, wb.b_ready, stall, ga, gb, exp_stall);
      end
      tick();
      checks++;
      if (RegWr !== m_regwr || RW !== m_rw || BusW !== m_busw || iss_conflict !== m_conf) begin
        errors++;
        $display("FAIL rand_out[%0d]: got RegWr=%b RW=%0d BusW=%h conf=%b expected RegWr=%b RW=%0d BusW=%h conf=%b",
                 n, RegWr, RW, BusW, iss_conflict, m_regwr, m_rw, m_busw, m_conf);
      end
      a_hold = wb.a_valid && !ga;
      b_hold = wb.b_valid && !gb;
    end
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_a_only();
    test_r0_drop();
    test_starvation();
    test_scoreboard();
    test_conflict();
    test_reset_midop();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/regfile_wb_ctrl.md
Name: regfile_wb_ctrl

Overview:
- Write-port controller and scoreboard for the 32x32 register file.
- Two writeback sources share the single synchronous write port (RegWr/RW/BusW):
  - A: the main pipeline writeback.
  - B: a long-latency unit (mul/div, load miss).
- Tracks registers with outstanding long-latency results and raises a read-hazard stall for the decode stage.
- Drives RegWr/RW/BusW from flops. The register file commits on the following negedge of clk.

Parameters:
DATA_W, 32, writeback data width
ADDR_W, 5, register address width (32 registers, r0 hardwired zero)
STARVE_MAX, 3, consecutive cycles B may be denied before it gets priority over A

Ports:
clk  input  1  clock; all state updates on posedge
rst_n  input  1  asynchronous active-low reset
a_valid  input  1  source A has a write pending
a_ready  output  1  source A write accepted this cycle (combinational)
a_rd  input  ADDR_W  source A destination register
a_data  input  DATA_W  source A write data
b_valid  input  1  source B has a write pending
b_ready  output  1  source B write accepted this cycle (combinational)
b_rd  input  ADDR_W  source B destination register
b_data  input  DATA_W  source B write data
iss_valid  input  1  long-latency op issued this cycle
iss_rd  input  ADDR_W  destination of issued op
chk_ra  input  ADDR_W  decode read address A to hazard-check
chk_rb  input  ADDR_W  decode read address B to hazard-check
stall  output  1  decode must stall (combinational)
iss_conflict  output  1  sticky error: issue to an already-pending register
RegWr  output  1  register file write enable (registered)
RW  output  ADDR_W  register file write address (registered)
BusW  output  DATA_W  register file write data (registered)

Behaviour:
- Reset (rst_n low, asynchronous):
  - RegWr=0, RW=0, BusW=0.
  - pending[31:1]=0, starve_cnt=0, iss_conflict=0.
  - a_ready/b_ready follow the grant logic below; they are 0 while rst_n is low.
- Handshake: a transfer occurs when valid && ready at posedge. Sources hold rd/data stable until accepted.
- Grant, evaluated each cycle:
  - b_prio = (starve_cnt >= STARVE_MAX).
  - Only a_valid: grant A. Only b_valid: grant B.
  - Both valid: grant B if b_prio, else A.
  - At most one of a_ready/b_ready is high.
- starve_cnt:
  - Cleared when b_valid=0 or B is granted.
  - Otherwise increments, saturating at STARVE_MAX.
- Output register, at posedge:
  - If a grant occurred: RW<=granted rd, BusW<=granted data, RegWr<=(granted rd != 0).
  - Else: RegWr<=0; RW/BusW hold.
  - rd=0 requests are accepted and consumed with no write.
- Latency: data accepted at posedge N is driven from N to N+1 and committed by the file at the negedge inside cycle N. It is readable from cycle N+1.
- Scoreboard, at posedge:
  - Set: iss_valid && iss_rd!=0 sets pending[iss_rd].
  - Clear: a B transfer with b_rd!=0 clears pending[b_rd].
  - Set and clear of the same register in the same cycle: set wins.
  - A transfers never touch pending.
- iss_conflict:
  - Set, and held until reset, when iss_valid && iss_rd!=0 && pending[iss_rd] is already 1.
  - The pending bit stays 1; only one outstanding write per register is supported.
- stall = (chk_ra!=0 && pending[chk_ra]) || (chk_rb!=0 && pending[chk_rb]) || (iss_valid && iss_rd!=0 && (iss_rd==chk_ra || iss_rd==chk_rb)).
  - stall stays high on the cycle B is accepted, since pending clears at that edge.
  - No bypass from b_data.
- Reset mid-operation: a write in the output register is dropped (RegWr forced 0) and all pending bits are lost. Upstream must flush.

Test Plan:
- Reset: rst_n=0 with a_valid=1, a_rd=5 -> RegWr=0, RW=0, BusW=0, stall=0, a_ready=0. Release -> a_ready=1 next cycle.
- A only: a_valid=1, a_rd=7, a_data=0xDEADBEEF for 1 cycle -> next cycle RegWr=1, RW=7, BusW=0xDEADBEEF. Following cycle RegWr=0.
- r0 drop: b_valid=1, b_rd=0, b_data=0x1234 -> b_ready=1, then RegWr=0 next cycle.
- Starvation: a_valid and b_valid held high with STARVE_MAX=3 -> A is granted 3 cycles, B granted on the 4th, then starve_cnt=0 and A is granted again.
- Scoreboard:
  - iss_valid=1, iss_rd=9; next cycle chk_ra=9 -> stall=1.
  - B transfer with b_rd=9 -> stall=0 from the cycle after acceptance.
  - chk_rb=0 -> never stalls.
- Conflict and same-cycle set/clear:
  - Issue rd=4 twice without a B write -> iss_conflict=1 (sticky).
  - B write rd=4 in the same cycle as iss_rd=4 -> pending[4] remains 1.
